// File: rtl/word_32_bit_uart_tx.sv
// word_32_bit_uart_tx
// Debug-link transmitter: sends a 32-bit word as four tagged byte pairs
// (tag 0x01..0x04 followed by the data byte, low byte first) or a single
// command as tag 0x00 followed by the command byte, all as 8N1 UART frames
// with a configurable number of idle bit periods after every byte.
module word_32_bit_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IDLE_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] tx_word,
  input  logic        tx_cmd,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int GW = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] G_LAST = GW'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_cnt;
  logic [2:0]      byte_idx;
  logic [GW-1:0]   gap_cnt;
  logic [31:0]     word_q;
  logic            cmd_q;
  logic [7:0]      shift;

  logic            period_end;
  logic            byte_end;
  logic            last_byte;

  // Byte k of a frame: tags on even slots, data on odd slots (word mode),
  // or a 0x00 tag followed by the command byte (command mode).
  function automatic logic [7:0] byte_for(input logic [2:0] k,
                                          input logic cmd,
                                          input logic [31:0] w);
    logic [7:0] b;
    if (cmd)
      b = (k == 3'd0) ? 8'h00 : w[7:0];
    else if (!k[0])
      b = {6'd0, k[2:1]} + 8'd1;
    else
      b = w[{k[2:1], 3'b000} +: 8];
    return b;
  endfunction

  // Detects the final cycle of a bit period and of a complete byte slot.
  always_comb begin
    period_end = (timer == T_LAST);
    byte_end   = 1'b0;
    if (period_end) begin
      if (state == S_STOP && IDLE_BITS == 0)
        byte_end = 1'b1;
      else if (state == S_GAP && gap_cnt == G_LAST)
        byte_end = 1'b1;
    end
    last_byte = cmd_q ? (byte_idx == 3'd1) : (byte_idx == 3'd7);
  end

  // Frame sequencer, bit timer and serializer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      gap_cnt  <= '0;
      word_q   <= '0;
      cmd_q    <= 1'b0;
      shift    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx       <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            word_q   <= tx_word;
            cmd_q    <= tx_cmd;
            byte_idx <= 3'd0;
            shift    <= byte_for(3'd0, tx_cmd, tx_word);
            timer    <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= S_START;
          end else begin
            state <= S_IDLE;
          end
        end
        S_START: begin
          if (period_end) begin
            timer <= '0;
            tx    <= shift[0];
            state <= S_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          if (period_end) begin
            timer <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              tx      <= 1'b1;
              state   <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_STOP: begin
          if (period_end) begin
            timer   <= '0;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_GAP: begin
          if (period_end) begin
            timer   <= '0;
            gap_cnt <= gap_cnt + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (byte_end) begin
        gap_cnt <= '0;
        if (last_byte) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end else begin
          byte_idx <= byte_idx + 3'd1;
          shift    <= byte_for(byte_idx + 3'd1, cmd_q, word_q);
          tx       <= 1'b0;
          state    <= S_START;
        end
      end
    end
  end

endmodule

// File: tb/tb_word_32_bit_uart_tx.sv
// Bench for word_32_bit_uart_tx: table of frames with expected byte
// sequences and done timing, a UART monitor that decodes tx against a
// scoreboard queue, and hand-written reset sequences.
module tb_word_32_bit_uart_tx;

  localparam int CPB = 4;
  localparam int IB  = 1;
  localparam int MID = CPB / 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        tx_cmd = 1'b0;
  logic [31:0] tx_word = 32'd0;
  logic        busy;
  logic        done;
  logic        tx;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] word;
    logic        cmd;
    int          nbytes;
    logic [63:0] exp_bytes;
    int          done_at;
    bit          b2b;
    int          inject_at;
  } vec_t;

  vec_t vecs[5];

  word_32_bit_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .IDLE_BITS(IB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_word(tx_word),
    .tx_cmd(tx_cmd),
    .start(start),
    .busy(busy),
    .done(done),
    .tx(tx)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // UART monitor: finds a start bit, samples each bit mid-period and
  // compares the decoded byte against the scoreboard.
  bit         mon_active = 1'b0;
  int         mon_off = 0;
  logic [7:0] mon_byte = 8'd0;
  logic       mon_start_ok = 1'b0;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_off = 0;
      end
    end else begin
      mon_off++;
      if (mon_off == MID) begin
        mon_start_ok = (tx === 1'b0);
      end else if (mon_off >= MID + CPB && mon_off <= MID + 8 * CPB && ((mon_off - MID) % CPB) == 0) begin
        mon_byte[(mon_off - MID) / CPB - 1] = tx;
      end else if (mon_off == MID + 9 * CPB) begin
        checkOutput("start_bit", {31'd0, mon_start_ok}, 32'd1);
        checkOutput("stop_bit", {31'd0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: got %0h expected none", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("uart_byte", {24'd0, mon_byte}, {24'd0, mon_exp});
        end
        mon_active = 1'b0;
      end
    end
  end

  // Expect n quiet cycles: line high, not busy, no done.
  task automatic idleCheck(input int n);
    int bad = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checkOutput("idle_quiet", bad, 0);
  endtask

  // Send one table frame starting now (called #1 after a rising edge) and
  // follow it to its done pulse.
  task automatic applyStimulus(input int idx);
    vec_t v = vecs[idx];
    int k;
    int done_k;
    int busy_bad;
    tx_word = v.word;
    tx_cmd  = v.cmd;
    start   = 1'b1;
    for (int b = 0; b < v.nbytes; b++) exp_q.push_back(v.exp_bytes[8*b +: 8]);
    @(posedge clk); #1;
    start   = 1'b0;
    tx_word = ~v.word;
    tx_cmd  = ~v.cmd;
    checkOutput("first_edge_tx", {31'd0, tx}, 32'd0);
    checkOutput("first_edge_busy", {31'd0, busy}, 32'd1);
    checkOutput("single_done", {31'd0, done}, 32'd0);
    k = 1;
    done_k = 0;
    busy_bad = 0;
    while (done_k == 0 && k < 1000) begin
      if (k == v.inject_at) begin
        tx_word = 32'h11111111;
        tx_cmd  = 1'b0;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (done === 1'b1) done_k = k;
      else if (busy !== 1'b1) busy_bad++;
    end
    start = 1'b0;
    checkOutput("done_cycle", done_k, v.done_at);
    checkOutput("busy_window", busy_bad, 0);
    checkOutput("busy_low_at_done", {31'd0, busy}, 32'd0);
    checkOutput("tx_high_at_done", {31'd0, tx}, 32'd1);
    checkOutput("all_bytes_sent", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{32'hDEADBEEF, 1'b0, 8, 64'hDE04_AD03_BE02_EF01, 353, 1'b0, 50};
    vecs[1] = '{32'hCAFEF00D, 1'b0, 8, 64'hCA04_FE03_F002_0D01, 353, 1'b1, 0};
    vecs[2] = '{32'h12345678, 1'b1, 2, 64'h0000_0000_0000_7800, 89, 1'b0, 0};
    vecs[3] = '{32'hFFFFFFA5, 1'b1, 2, 64'h0000_0000_0000_A500, 89, 1'b0, 0};
    vecs[4] = '{32'h00000000, 1'b0, 8, 64'h0004_0003_0002_0001, 353, 1'b0, 0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (!vecs[i].b2b) idleCheck(20);
      applyStimulus(i);
    end
    idleCheck(20);

    $display("[TB] reset during byte 3 data bits");
    tx_word = vecs[0].word;
    tx_cmd  = 1'b0;
    start   = 1'b1;
    for (int b = 0; b < 8; b++) exp_q.push_back(vecs[0].exp_bytes[8*b +: 8]);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (149) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset_tx", {31'd0, tx}, 32'd1);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_bytes_left", exp_q.size(), 5);
    exp_q.delete();
    idleCheck(400);
    applyStimulus(4);
    idleCheck(10);

    $display("[TB] reset and start together");
    reset   = 1'b1;
    start   = 1'b1;
    tx_word = 32'hFFFFFFFF;
    tx_cmd  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    idleCheck(100);
    checkOutput("priority_no_bytes", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_32_bit_uart_tx.md
# word_32_bit_uart_tx

Serial transmitter for the debug link: sends one 32-bit word, or one 8-bit command, as a sequence of tagged 8N1 UART bytes on a single `tx` line. It is the host-bound counterpart of the debug word receiver and uses the same framing. Word mode sends `tag 0x01, byte0, tag 0x02, byte1, tag 0x03, byte2, tag 0x04, byte3`, where byte0 = bits [7:0]. Command mode sends `tag 0x00, cmd`. The block contains its own bit-timing counter and byte serializer.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit period; legal values are ≥ 2.
- IDLE_BITS, 1, number of idle (high) bit periods inserted after every byte, including the last one.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_word  in  32  word to send; in command mode only [7:0] is used.
- tx_cmd  in  1  0 = word mode (8 bytes), 1 = command mode (2 bytes); sampled together with `start`.
- start  in  1  request; accepted only in a cycle where `busy` = 0.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when the frame is complete.
- tx  out  1  serial output; idle level is high; registered.

## Operation
- **Reset values:** `tx` = 1, `busy` = 0, `done` = 0, state = IDLE, all counters = 0.
- **Accept:** in a cycle where `start` = 1 and `busy` = 0, latch `tx_word` and `tx_cmd` and set byte index k = 0.
- **Ignored start:** `start` while `busy` = 1 is ignored. Changes on `tx_word` or `tx_cmd` after acceptance have no effect.
- **Byte selection, word mode** (k = 0..7):
  - even k → tag value k/2 + 1;
  - odd k → latched word bits [8·(k−1)/2 + 7 : 8·(k−1)/2].
- **Byte selection, command mode** (k = 0..1):
  - k = 0 → 0x00;
  - k = 1 → latched bits [7:0].
- **Byte frame:** start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts CLKS_PER_BIT cycles. After the stop bit, IDLE_BITS·CLKS_PER_BIT cycles with `tx` = 1.
- **State machine:**
  - IDLE → START on accept.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bit periods; the bit counter runs 0..7.
  - STOP → GAP after CLKS_PER_BIT cycles. If IDLE_BITS = 0, STOP goes directly to the next-byte decision.
  - GAP → START with k+1 if k < last index (7 in word mode, 1 in command mode); otherwise GAP → DONE.
  - DONE → IDLE after one cycle.
- **Counter widths:** the bit-timer is $clog2(CLKS_PER_BIT) bits, the bit counter is 3 bits, and the byte index is 3 bits. No counter wraps during a frame.
- **Reset mid-frame:** the frame is abandoned and no `done` pulse is produced. The next cycle shows reset values. A subsequent accept sends a complete frame starting from its first tag byte.
- **`reset` and `start` in the same cycle:** `reset` wins and the request is dropped.

## Timing
- **First edge:** accept at cycle N puts `tx` = 0 (start bit of byte 0) at cycle N+1.
- **Busy window:** `busy` = 1 from cycle N+1 through the last GAP cycle.
- **Frame length:** let F = (10 + IDLE_BITS)·CLKS_PER_BIT.
  - Word mode: busy lasts 8·F cycles, and `done` = 1 at cycle N+1+8·F.
  - Command mode: busy lasts 2·F cycles, and `done` = 1 at cycle N+1+2·F.
- **DONE cycle:** `busy` = 0 and `tx` = 1, so `start` is accepted in the DONE cycle. A back-to-back accept at the `done` cycle D gives a start bit at D+1, with no extra gap beyond IDLE_BITS.
- **Gap between bytes:** exactly IDLE_BITS·CLKS_PER_BIT cycles between one byte's stop bit and the next start bit.
- **Glitch-free output:** `tx` changes only at bit-period boundaries.

## Test plan
All scenarios use CLKS_PER_BIT = 4 and IDLE_BITS = 1; a UART monitor on the bench decodes `tx`.

- **Word mode:** `tx_word` = 0xDEADBEEF, `tx_cmd` = 0, `start` pulsed at cycle N → monitor decodes 01 EF 02 BE 03 AD 04 DE with valid stop bits; `busy` high N+1..N+352; single `done` at N+353.
- **Command mode:** `tx_word` = 0x12345678, `tx_cmd` = 1 → monitor decodes 00 78; `done` at N+89; nothing further on `tx`.
- **Start while busy:** `start` with 0x11111111 at N+50 during a 0xDEADBEEF frame → ignored; the sequence is unchanged; exactly one `done`.
- **Back-to-back:** `start` with 0xCAFEF00D asserted in the `done` cycle D → start bit at D+1; decodes 01 0D 02 F0 03 FE 04 CA.
- **Reset mid-frame:** `reset` for one cycle during the DATA state of byte index 3 → next cycle `tx` = 1, `busy` = 0, and no `done`. A new accept of 0x00000000 then decodes 01 00 02 00 03 00 04 00.
- **Reset priority:** `reset` and `start` asserted together → no transmission; `tx` stays 1 for 100 cycles.
